// File: rtl/match_frame_sequencer.sv
// match_frame_sequencer: gates the corner stream to the matcher one frame at a time, capping each frame at MAX_CORNERS.
// Latency: 1 cycle from s00 handshake to m00_axis_tvalid, 1 bubble cycle per frame start, frame_done 1 cycle after drain.
// Backpressure: one-deep output register; s00 ready follows m00 ready in PASS, is forced high in DROP and low elsewhere.
// Optional feature macro FRAME_SEQ_STATS_EN: enables match_count/drop_count (both tied to 0 when undefined).
module match_frame_sequencer #(
  parameter int DATA_WIDTH  = 280,
  parameter int MAX_CORNERS = 1024,
  parameter int CNT_W       = 11,
  parameter int DROP_W      = 16
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  input  logic                  enable,
  input  logic                  empty_frame,
  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tlast,
  output logic                  s00_axis_tready,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready,
  input  logic                  match_tvalid,
  input  logic                  match_tready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      corner_count,
  output logic [DROP_W-1:0]     drop_count,
  output logic [CNT_W-1:0]      match_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_DROP,
    S_DRAIN,
    S_DONE
  } state_t;

  // Index of the last corner a frame may forward; reaching it forces tlast.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_CORNERS - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] out_dat_q;
  logic                  out_vld_q;
  logic                  out_lst_q;
  logic [CNT_W-1:0]      frame_cnt_q;
  logic [CNT_W-1:0]      corner_count_q;
  logic                  last_hs_q;     // last forwarded beat has been taken by the matcher
  logic                  frame_done_q;

  logic s_rdy;
  logic s_hs;
  logic m_hs;
  logic fwd_last;
  logic to_done_d;

  // Input ready: output-register slot in PASS, unconditional sink in DROP, closed otherwise.
  always_comb begin
    s_rdy = 1'b0;
    case (state_q)
      S_PASS:  s_rdy = !out_vld_q || m00_axis_tready;
      S_DROP:  s_rdy = 1'b1;
      default: s_rdy = 1'b0;
    endcase
  end

  assign s_hs     = s00_axis_tvalid && s_rdy;
  assign m_hs     = out_vld_q && m00_axis_tready;
  assign fwd_last = s00_axis_tlast || (frame_cnt_q == LAST_IDX);

  // Frame completion: empty frame seen in IDLE, or matcher ready again after taking the last beat.
  always_comb begin
    to_done_d = 1'b0;
    case (state_q)
      S_IDLE:  to_done_d = enable && empty_frame;
      S_DRAIN: to_done_d = last_hs_q && m00_axis_tready;
      default: to_done_d = 1'b0;
    endcase
  end

  // Frame FSM with the output register, frame counter and latched corner count.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q        <= S_IDLE;
      out_dat_q      <= '0;
      out_vld_q      <= 1'b0;
      out_lst_q      <= 1'b0;
      frame_cnt_q    <= '0;
      corner_count_q <= '0;
      last_hs_q      <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= to_done_d;
      if (to_done_d) begin
        corner_count_q <= frame_cnt_q;
      end

      // Only PASS loads the output register; any state may still hand it off.
      if (state_q == S_PASS && s_hs) begin
        out_dat_q <= s00_axis_tdata;
        out_vld_q <= 1'b1;
        out_lst_q <= fwd_last;
      end else if (m00_axis_tready) begin
        out_vld_q <= 1'b0;
      end

      if (m_hs && out_lst_q) begin
        last_hs_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          // The waiting beat is left in place; PASS consumes it next cycle.
          if (enable && empty_frame) begin
            frame_cnt_q <= '0;
            state_q     <= S_DONE;
          end else if (enable && s00_axis_tvalid) begin
            state_q <= S_PASS;
          end
        end
        S_PASS: begin
          if (s_hs) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            if (fwd_last) begin
              state_q <= s00_axis_tlast ? S_DRAIN : S_DROP;
            end
          end
        end
        S_DROP: begin
          if (s_hs && s00_axis_tlast) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (to_done_d) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          frame_cnt_q <= '0;
          last_hs_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FRAME_SEQ_STATS_EN
  logic [CNT_W-1:0]  match_acc_q;
  logic [CNT_W-1:0]  match_acc_d;
  logic [CNT_W-1:0]  match_count_q;
  logic [DROP_W-1:0] drop_count_q;
  logic              match_hs;

  assign match_hs = match_tvalid && match_tready &&
                    (state_q inside {S_PASS, S_DROP, S_DRAIN});

  // Saturating per-frame match accumulator; the next value lets a match in the final DRAIN cycle count.
  always_comb begin
    match_acc_d = match_acc_q;
    if (match_hs && (match_acc_q != '1)) begin
      match_acc_d = match_acc_q + CNT_W'(1);
    end
  end

  // Match accumulator/latch and the cumulative saturating drop counter.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      match_acc_q   <= '0;
      match_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (state_q == S_DONE) begin
        match_acc_q <= '0;
      end else begin
        match_acc_q <= match_acc_d;
      end
      if (to_done_d) begin
        match_count_q <= match_acc_d;
      end
      if (state_q == S_DROP && s_hs && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + DROP_W'(1);
      end
    end
  end

  assign match_count = match_count_q;
  assign drop_count  = drop_count_q;
`else
  // Matcher snoop has no consumer without the statistics registers.
  logic unused_match_snoop;
  assign unused_match_snoop = match_tvalid ^ match_tready;

  assign match_count = '0;
  assign drop_count  = '0;
`endif

  assign s00_axis_tready = s_rdy;
  assign m00_axis_tdata  = out_dat_q;
  assign m00_axis_tvalid = out_vld_q;
  assign m00_axis_tlast  = out_lst_q;
  assign busy            = (state_q != S_IDLE);
  assign frame_done      = frame_done_q;
  assign corner_count    = corner_count_q;

endmodule

// File: tb/tb_match_frame_sequencer.sv
// tb_match_frame_sequencer: directed bench for match_frame_sequencer with MAX_CORNERS=5.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: m00 ready driven directly or toggled every cycle by a helper process.
module tb_match_frame_sequencer;

  localparam int DW     = 32;
  localparam int MAXC   = 5;
  localparam int CNT_W  = 11;
  localparam int DROP_W = 16;
`ifdef FRAME_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              empty_frame;
  logic [DW-1:0]     s_dat;
  logic              s_vld;
  logic              s_lst;
  logic              s_rdy;
  logic [DW-1:0]     m_dat;
  logic              m_vld;
  logic              m_lst;
  logic              m_rdy;
  logic              match_vld;
  logic              match_rdy;
  logic              busy;
  logic              frame_done;
  logic [CNT_W-1:0]  corner_count;
  logic [DROP_W-1:0] drop_count;
  logic [CNT_W-1:0]  match_count;

  logic rdy_drv;
  logic toggle_en;
  logic tog = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int fd0;

  logic [DW-1:0] q_dat[$];
  logic          q_lst[$];
  logic [DW-1:0] exp_dat[$];
  logic          exp_lst[$];

  logic          stall_q = 1'b0;
  logic [DW-1:0] p_dat;
  logic          p_lst;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tog = ~tog;
  end

  assign m_rdy = toggle_en ? tog : rdy_drv;

  match_frame_sequencer #(
    .DATA_WIDTH (DW),
    .MAX_CORNERS(MAXC),
    .CNT_W      (CNT_W),
    .DROP_W     (DROP_W)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .enable          (enable),
    .empty_frame     (empty_frame),
    .s00_axis_tdata  (s_dat),
    .s00_axis_tvalid (s_vld),
    .s00_axis_tlast  (s_lst),
    .s00_axis_tready (s_rdy),
    .m00_axis_tdata  (m_dat),
    .m00_axis_tvalid (m_vld),
    .m00_axis_tlast  (m_lst),
    .m00_axis_tready (m_rdy),
    .match_tvalid    (match_vld),
    .match_tready    (match_rdy),
    .busy            (busy),
    .frame_done      (frame_done),
    .corner_count    (corner_count),
    .drop_count      (drop_count),
    .match_count     (match_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Matcher-side monitor: records handshaken beats, checks hold during stalls, counts frame_done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_hold", 64'({m_vld, m_lst, m_dat}), 64'({1'b1, p_lst, p_dat}));
      end
      if (m_vld && m_rdy) begin
        q_dat.push_back(m_dat);
        q_lst.push_back(m_lst);
      end
      stall_q = m_vld && !m_rdy;
      p_dat   = m_dat;
      p_lst   = m_lst;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    logic hs;
    int   waited;
    hs     = 1'b0;
    waited = 0;
    s_dat  = d;
    s_lst  = l;
    s_vld  = 1'b1;
    while (!hs && waited < 60) begin
      @(negedge clk);
      hs = s_rdy;
      tick();
      waited++;
    end
    s_vld = 1'b0;
    if (!hs) chk("send_timeout", 64'(hs), 64'(1'b1));
  endtask

  // Returns at the negedge where frame_done is high, or counts a failure on timeout.
  task automatic wait_done(input string tag, input int budget);
    logic seen;
    int   n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      seen = frame_done;
      if (!seen) tick();
      n++;
    end
    chk(tag, 64'(seen), 64'(1'b1));
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    exp_dat.push_back(d);
    exp_lst.push_back(l);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_beats"}, 64'(q_dat.size()), 64'(exp_dat.size()));
    for (int i = 0; i < exp_dat.size() && i < q_dat.size(); i++) begin
      chk($sformatf("%s_dat%0d", tag, i), 64'(q_dat[i]), 64'(exp_dat[i]));
      chk($sformatf("%s_lst%0d", tag, i), 64'(q_lst[i]), 64'(exp_lst[i]));
    end
    q_dat.delete();
    q_lst.delete();
    exp_dat.delete();
    exp_lst.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tready"}, 64'(s_rdy), 64'(1'b0));
    chk({tag, "_tvalid"}, 64'(m_vld), 64'(1'b0));
    chk({tag, "_tlast"}, 64'(m_lst), 64'(1'b0));
    chk({tag, "_tdata"}, 64'(m_dat), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
    chk({tag, "_frame_done"}, 64'(frame_done), 64'(1'b0));
    chk({tag, "_corner_count"}, 64'(corner_count), 64'(0));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(0));
    chk({tag, "_match_count"}, 64'(match_count), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    empty_frame = 1'b0;
    s_dat       = '0;
    s_vld       = 1'b0;
    s_lst       = 1'b0;
    rdy_drv     = 1'b1;
    toggle_en   = 1'b0;
    match_vld   = 1'b0;
    match_rdy   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Frame 1: 3 corners, matcher always ready; checks the start bubble and 1-cycle latency
    fd0    = fd_cnt;
    enable = 1'b1;
    s_dat  = 32'h11;
    s_lst  = 1'b0;
    s_vld  = 1'b1;
    @(negedge clk);
    chk("f1_idle_tready", 64'(s_rdy), 64'(1'b0));
    chk("f1_idle_busy", 64'(busy), 64'(1'b0));
    tick();
    @(negedge clk);
    chk("f1_pass_tready", 64'(s_rdy), 64'(1'b1));
    chk("f1_pass_busy", 64'(busy), 64'(1'b1));
    chk("f1_pre_tvalid", 64'(m_vld), 64'(1'b0));
    tick();
    s_vld = 1'b0;
    @(negedge clk);
    chk("f1_lat_tvalid", 64'(m_vld), 64'(1'b1));
    chk("f1_lat_tdata", 64'(m_dat), 64'(32'h11));
    tick();
    send_beat(32'h12, 1'b0);
    send_beat(32'h13, 1'b1);
    wait_done("f1_done", 40);
    chk("f1_corner_count", 64'(corner_count), 64'(3));
    chk("f1_drop_count", 64'(drop_count), 64'(0));
    chk("f1_match_count", 64'(match_count), 64'(0));
    tick();
    tick();
    chk("f1_done_pulses", 64'(fd_cnt - fd0), 64'(1));
    expect_beat(32'h11, 1'b0);
    expect_beat(32'h12, 1'b0);
    expect_beat(32'h13, 1'b1);
    check_stream("f1");

    // Frame 2: 8 corners against a cap of 5; tlast forced on the 5th, 3 dropped
    fd0 = fd_cnt;
    for (int i = 1; i <= 8; i++) begin
      send_beat(DW'(32'h20 + i), (i == 8));
    end
    wait_done("f2_done", 40);
    chk("f2_corner_count", 64'(corner_count), 64'(5));
    chk("f2_drop_count", 64'(drop_count), 64'(STATS ? 3 : 0));
    tick();
    tick();
    chk("f2_done_pulses", 64'(fd_cnt - fd0), 64'(1));
    for (int i = 1; i <= 5; i++) begin
      expect_beat(DW'(32'h20 + i), (i == 5));
    end
    check_stream("f2");

    // Frame 3: exactly 5 corners with ready toggling every cycle
    toggle_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_beat(DW'(32'h30 + i), (i == 5));
    end
    wait_done("f3_done", 60);
    chk("f3_corner_count", 64'(corner_count), 64'(5));
    chk("f3_drop_count", 64'(drop_count), 64'(STATS ? 3 : 0));
    tick();
    toggle_en = 1'b0;
    rdy_drv   = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      expect_beat(DW'(32'h30 + i), (i == 5));
    end
    check_stream("f3");

    // Frame 4: matcher holds ready low for 20 cycles after the last beat; next frame waits
    send_beat(32'h41, 1'b0);
    send_beat(32'h42, 1'b1);
    tick();
    rdy_drv = 1'b0;
    s_dat   = 32'h51;
    s_lst   = 1'b1;
    s_vld   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      match_vld = (i < 4);
      match_rdy = (i < 3);
      @(negedge clk);
      chk($sformatf("f4_hold_busy%0d", i), 64'(busy), 64'(1'b1));
      chk($sformatf("f4_hold_tready%0d", i), 64'(s_rdy), 64'(1'b0));
      chk($sformatf("f4_hold_done%0d", i), 64'(frame_done), 64'(1'b0));
      tick();
    end
    match_vld = 1'b0;
    match_rdy = 1'b0;
    rdy_drv   = 1'b1;
    @(negedge clk);
    chk("f4_release_done", 64'(frame_done), 64'(1'b0));
    tick();
    @(negedge clk);
    chk("f4_done", 64'(frame_done), 64'(1'b1));
    chk("f4_corner_count", 64'(corner_count), 64'(2));
    chk("f4_match_count", 64'(match_count), 64'(STATS ? 3 : 0));
    tick();
    send_beat(32'h51, 1'b1);
    wait_done("f5_done", 40);
    chk("f5_corner_count", 64'(corner_count), 64'(1));
    chk("f5_match_count", 64'(match_count), 64'(0));
    tick();
    tick();
    expect_beat(32'h41, 1'b0);
    expect_beat(32'h42, 1'b1);
    expect_beat(32'h51, 1'b1);
    check_stream("f4");

    // Empty frame with enable low is ignored
    enable      = 1'b0;
    empty_frame = 1'b1;
    tick();
    empty_frame = 1'b0;
    @(negedge clk);
    chk("ef_disabled_done", 64'(frame_done), 64'(1'b0));
    chk("ef_disabled_busy", 64'(busy), 64'(1'b0));
    tick();

    // Empty frame with enable high wins over a waiting beat
    fd0         = fd_cnt;
    enable      = 1'b1;
    empty_frame = 1'b1;
    s_dat       = 32'h61;
    s_lst       = 1'b1;
    s_vld       = 1'b1;
    @(negedge clk);
    chk("ef_same_cycle_done", 64'(frame_done), 64'(1'b0));
    tick();
    empty_frame = 1'b0;
    @(negedge clk);
    chk("ef_done", 64'(frame_done), 64'(1'b1));
    chk("ef_corner_count", 64'(corner_count), 64'(0));
    chk("ef_match_count", 64'(match_count), 64'(0));
    chk("ef_tvalid", 64'(m_vld), 64'(1'b0));
    chk("ef_tready", 64'(s_rdy), 64'(1'b0));
    tick();
    send_beat(32'h61, 1'b1);
    wait_done("ef_next_done", 40);
    chk("ef_next_corner_count", 64'(corner_count), 64'(1));
    tick();
    tick();
    chk("ef_done_pulses", 64'(fd_cnt - fd0), 64'(2));
    expect_beat(32'h61, 1'b1);
    check_stream("ef");

    // Reset mid-PASS after two beats, then a clean 2-corner frame
    send_beat(32'h71, 1'b0);
    send_beat(32'h72, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    tick();
    rst_n = 1'b1;
    q_dat.delete();
    q_lst.delete();
    tick();
    send_beat(32'h81, 1'b0);
    send_beat(32'h82, 1'b1);
    wait_done("rst_f_done", 40);
    chk("rst_f_corner_count", 64'(corner_count), 64'(2));
    chk("rst_f_drop_count", 64'(drop_count), 64'(0));
    tick();
    tick();
    expect_beat(32'h81, 1'b0);
    expect_beat(32'h82, 1'b1);
    check_stream("rst_f");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
